// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue stage:
//     - 4-bit ALU opcode constants (ADD..NAND = 0x0..0x8, EQ0 = 0xE, SLT = 0xF)
//     - issue-stage FSM state encoding
//     - isLegalOp(): true for every opcode the ALU defines; 0x9..0xD are holes
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_EQ0  = 4'hE;
    localparam logic [3:0] OP_SLT  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic isLegalOp(input logic [3:0] op);
        return (op <= OP_NAND) || (op == OP_EQ0) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_issue_stage_settle_counter.sv
// ---------------------------------------------------------------------------
// settle_counter
//   4-bit down-counter that times how long the ALU inputs are held before the
//   result is captured.
//   Ports:
//     clk        rising-edge clock
//     rst_n      async active-low reset (counter -> 0)
//     load       load load_value (wins over dec)
//     load_value value to load
//     dec        decrement by one; holds at zero
//     zero       count is zero
// ---------------------------------------------------------------------------
module settle_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Execute-stage front end for a 16-bit combinational ALU. One request is
//   accepted over valid/ready, its opcode/operands are registered onto the ALU
//   inputs, held for SETTLE_CYCLES, then result/zero/tag/illegal are captured
//   and held on a valid/ready response port until consumed.
//
//   Parameters: WIDTH (operand width), TAG_W (tag width),
//               SETTLE_CYCLES (1..15, cycles between driving ALU and capture)
//
//   Ports:
//     clk, resetN             clock, async active-low reset
//     flush                   sync discard of in-flight op / held response
//     reqValid/reqReady       request handshake
//     reqOp, reqA, reqB, reqTag  request payload
//     aluOp, aIn, bIn         registered ALU inputs
//     aluResult, aluZero      ALU outputs
//     rspValid/rspReady       response handshake
//     rspData, rspZero, rspIllegal, rspTag  captured response
//
//   Optional feature, enabled by defining ALU_ISSUE_PERF_EN:
//     opCount    accepted requests, saturating at 0xFFFF, cleared only by reset
//     stallCount cycles in DONE with rspReady low, saturating, reset-only clear
// ---------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int TAG_W         = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             flush,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [3:0]       reqOp,
    input  logic [WIDTH-1:0] reqA,
    input  logic [WIDTH-1:0] reqB,
    input  logic [TAG_W-1:0] reqTag,
    output logic [3:0]       aluOp,
    output logic [WIDTH-1:0] aIn,
    output logic [WIDTH-1:0] bIn,
    input  logic [WIDTH-1:0] aluResult,
    input  logic             aluZero,
    output logic             rspValid,
    input  logic             rspReady,
    output logic [WIDTH-1:0] rspData,
    output logic             rspZero,
    output logic             rspIllegal,
`ifdef ALU_ISSUE_PERF_EN
    output logic [TAG_W-1:0] rspTag,
    output logic [15:0]      opCount,
    output logic [15:0]      stallCount
`else
    output logic [TAG_W-1:0] rspTag
`endif
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("alu_issue_stage: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state_reg;
    logic [3:0]       alu_op_reg;
    logic [WIDTH-1:0] a_in_reg;
    logic [WIDTH-1:0] b_in_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_zero_reg;
    logic             rsp_illegal_reg;
    logic [TAG_W-1:0] rsp_tag_reg;

    logic accept;
    logic settle_zero;
    logic settle_dec;

    // Ready is suppressed during flush so that no handshake is ever signalled
    // for a request that the flush would drop.
    assign reqReady = ~flush & ((state_reg == IDLE) |
                                ((state_reg == DONE) & rspReady));
    assign accept   = reqValid & reqReady;

    assign settle_dec = (state_reg == EXEC) & ~settle_zero;

    settle_counter u_settle (
        .clk        (clk),
        .rst_n      (resetN),
        .load       (accept),
        .load_value (SETTLE_LOAD),
        .dec        (settle_dec),
        .zero       (settle_zero)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg       <= IDLE;
            alu_op_reg      <= 4'd0;
            a_in_reg        <= '0;
            b_in_reg        <= '0;
            tag_reg         <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_zero_reg    <= 1'b0;
            rsp_illegal_reg <= 1'b0;
            rsp_tag_reg     <= '0;
        end else if (flush) begin
            // ALU input registers deliberately keep their last value.
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                alu_op_reg <= reqOp;
                a_in_reg   <= reqA;
                b_in_reg   <= reqB;
                tag_reg    <= reqTag;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (settle_zero) begin
                        rsp_data_reg    <= aluResult;
                        rsp_zero_reg    <= aluZero;
                        rsp_illegal_reg <= ~isLegalOp(alu_op_reg);
                        rsp_tag_reg     <= tag_reg;
                        rsp_valid_reg   <= 1'b1;
                        state_reg       <= DONE;
                    end
                end
                DONE: begin
                    if (rspReady) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign aluOp      = alu_op_reg;
    assign aIn        = a_in_reg;
    assign bIn        = b_in_reg;
    assign rspValid   = rsp_valid_reg;
    assign rspData    = rsp_data_reg;
    assign rspZero    = rsp_zero_reg;
    assign rspIllegal = rsp_illegal_reg;
    assign rspTag     = rsp_tag_reg;

`ifdef ALU_ISSUE_PERF_EN
    // Two saturating event counters: index 0 counts accepts, index 1 counts
    // response stall cycles.
    logic [1:0]  perf_inc;
    logic [15:0] perf_count_reg [2];

    assign perf_inc[0] = accept;
    assign perf_inc[1] = (state_reg == DONE) & ~rspReady;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    perf_count_reg[gi] <= 16'd0;
                end else if (perf_inc[gi] && (perf_count_reg[gi] != 16'hFFFF)) begin
                    perf_count_reg[gi] <= perf_count_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign opCount    = perf_count_reg[0];
    assign stallCount = perf_count_reg[1];
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//   Directed bench for alu_issue_stage with a behavioural ALU stub. Expected
//   responses are pushed into a queue when a request is accepted; a monitor
//   pops and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int WIDTH = 16;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             resetN;
    logic             flush;
    logic             reqValid;
    logic             reqReady;
    logic [3:0]       reqOp;
    logic [WIDTH-1:0] reqA;
    logic [WIDTH-1:0] reqB;
    logic [TAG_W-1:0] reqTag;
    logic [3:0]       aluOp;
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic [WIDTH-1:0] aluResult;
    logic             aluZero;
    logic             rspValid;
    logic             rspReady;
    logic [WIDTH-1:0] rspData;
    logic             rspZero;
    logic             rspIllegal;
    logic [TAG_W-1:0] rspTag;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0]      opCount;
    logic [15:0]      stallCount;
`endif

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .SETTLE_CYCLES(1)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .flush      (flush),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqOp      (reqOp),
        .reqA       (reqA),
        .reqB       (reqB),
        .reqTag     (reqTag),
        .aluOp      (aluOp),
        .aIn        (aIn),
        .bIn        (bIn),
        .aluResult  (aluResult),
        .aluZero    (aluZero),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspData    (rspData),
        .rspZero    (rspZero),
        .rspIllegal (rspIllegal),
`ifdef ALU_ISSUE_PERF_EN
        .rspTag     (rspTag),
        .opCount    (opCount),
        .stallCount (stallCount)
`else
        .rspTag     (rspTag)
`endif
    );

    // Behavioural ALU: undefined opcodes yield 0.
    always_comb begin
        aluResult = '0;
        case (aluOp)
            4'h0: aluResult = aIn + bIn;
            4'h1: aluResult = aIn - bIn;
            4'h2: aluResult = aIn & bIn;
            4'h3: aluResult = aIn | bIn;
            4'h4: aluResult = aIn ^ bIn;
            4'h5: aluResult = aIn << bIn[3:0];
            4'h6: aluResult = aIn >> bIn[3:0];
            4'h7: aluResult = ~(aIn | bIn);
            4'h8: aluResult = ~(aIn & bIn);
            4'hE: aluResult = {15'd0, (aIn == '0)};
            4'hF: aluResult = {15'd0, ($signed(aIn) < $signed(bIn))};
            default: aluResult = '0;
        endcase
    end
    assign aluZero = (aluResult == '0);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every consumed response against the scoreboard head.
    always @(negedge clk) begin
        if (resetN && rspValid && rspReady && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rspData), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", 32'(rspData), 32'(e.data));
                chk("rsp_zero", 32'(rspZero), 32'(e.zero));
                chk("rsp_illegal", 32'(rspIllegal), 32'(e.ill));
                chk("rsp_tag", 32'(rspTag), 32'(e.tag));
                $display("rsp: data=%04h zero=%0d ill=%0d tag=%0d", rspData, rspZero, rspIllegal, rspTag);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] tag, input logic [15:0] ed, input logic ez,
                        input logic ei, input bit push);
        bit done;
        done     = 1'b0;
        reqValid = 1'b1;
        reqOp    = op;
        reqA     = a;
        reqB     = b;
        reqTag   = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (reqReady) begin
                done = 1'b1;
                if (push) exp_q.push_back('{data: ed, zero: ez, ill: ei, tag: tag});
                $display("req: op=%0h a=%04h b=%04h tag=%0d", op, a, b, tag);
            end
            step();
        end
        if (!done) chk("req_accept_timeout", 32'd0, 32'd1);
        reqValid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_aluOp"}, 32'(aluOp), 32'd0);
        chk({tag, "_aIn"}, 32'(aIn), 32'd0);
        chk({tag, "_bIn"}, 32'(bIn), 32'd0);
        chk({tag, "_rspValid"}, 32'(rspValid), 32'd0);
        chk({tag, "_rspData"}, 32'(rspData), 32'd0);
        chk({tag, "_rspZero"}, 32'(rspZero), 32'd0);
        chk({tag, "_rspIllegal"}, 32'(rspIllegal), 32'd0);
        chk({tag, "_rspTag"}, 32'(rspTag), 32'd0);
    endtask

    initial begin
        resetN   = 1'b0;
        flush    = 1'b0;
        reqValid = 1'b0;
        reqOp    = 4'd0;
        reqA     = '0;
        reqB     = '0;
        reqTag   = '0;
        rspReady = 1'b0;

        // 1: reset, then reset again mid-EXEC
        @(negedge clk);
        chk_reset_outputs("reset");
        step();
        resetN = 1'b1;
        step();
        send(4'h0, 16'h1111, 16'h2222, 3'd1, 16'h0, 1'b0, 1'b0, 1'b0);
        resetN = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midexec_reset");
        step();
        resetN = 1'b1;
        @(negedge clk);
        chk("post_reset_reqReady", 32'(reqReady), 32'd1);
        step();

        // 2: ADD with latency check
        rspReady = 1'b1;
        send(4'h0, 16'h0003, 16'h0004, 3'd5, 16'h0007, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("add_lat_exec_rspValid", 32'(rspValid), 32'd0);
        step();
        @(negedge clk);
        chk("add_lat_rspValid", 32'(rspValid), 32'd1);
        chk("add_rspData", 32'(rspData), 32'h0007);
        chk("add_rspTag", 32'(rspTag), 32'd5);
        step();

        // 3: SUB to zero, response held while rspReady low
        rspReady = 1'b0;
        send(4'h1, 16'h1234, 16'h1234, 3'd3, 16'h0000, 1'b1, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sub_hold_rspValid", 32'(rspValid), 32'd1);
            chk("sub_hold_rspData", 32'(rspData), 32'h0000);
            chk("sub_hold_rspZero", 32'(rspZero), 32'd1);
            chk("sub_hold_reqReady", 32'(reqReady), 32'd0);
            step();
        end
        rspReady = 1'b1;
        step();

        // 4: back-to-back OR then XOR
        send(4'h3, 16'h00F0, 16'h000F, 3'd1, 16'h00FF, 1'b0, 1'b0, 1'b1);
        reqValid = 1'b1;
        reqOp    = 4'h4;
        reqA     = 16'hFFFF;
        reqB     = 16'h00FF;
        reqTag   = 3'd2;
        @(negedge clk);
        chk("b2b_exec_reqReady", 32'(reqReady), 32'd0);
        step();
        @(negedge clk);
        chk("b2b_done_rspValid", 32'(rspValid), 32'd1);
        chk("b2b_same_cycle_reqReady", 32'(reqReady), 32'd1);
        if (reqReady) exp_q.push_back('{data: 16'hFF00, zero: 1'b0, ill: 1'b0, tag: 3'd2});
        $display("req: op=4 a=ffff b=00ff tag=2");
        step();
        reqValid = 1'b0;
        repeat (3) step();

        // 5: illegal opcode
        send(4'hA, 16'h1234, 16'h5678, 3'd6, 16'h0000, 1'b1, 1'b1, 1'b1);
        repeat (3) step();

        // 6a: flush in EXEC
        rspReady = 1'b0;
        send(4'h0, 16'h0001, 16'h0002, 3'd4, 16'h0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_exec_reqReady", 32'(reqReady), 32'd0);
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_exec_no_rsp", 32'(rspValid), 32'd0);
            step();
        end
        @(negedge clk);
        chk("flush_exec_idle", 32'(reqReady), 32'd1);
        step();

        // 6b: flush in DONE coincident with a new request
        send(4'h2, 16'hF0F0, 16'h0FF0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        chk("flush_done_rspValid_before", 32'(rspValid), 32'd1);
        step();
        flush    = 1'b1;
        reqValid = 1'b1;
        reqOp    = 4'h0;
        reqA     = 16'h0005;
        reqB     = 16'h0005;
        reqTag   = 3'd7;
        @(negedge clk);
        chk("flush_done_reqReady", 32'(reqReady), 32'd0);
        step();
        flush    = 1'b0;
        reqValid = 1'b0;
        @(negedge clk);
        chk("flush_done_idle", 32'(reqReady), 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_done_no_rsp", 32'(rspValid), 32'd0);
            step();
        end

        // drain
        rspReady = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
